mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single unified instruction/data memory between the multicycle core and the program-loader/DMA master. It sits between the core's memory interface (fetch and load/store) and the memory macro. It grants one access at a time with round-robin fairness, sequences fixed-latency reads, and returns read data to the owning requester.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- RD_LAT, 1, memory read latency in cycles; legal range 1..4

Ports (requester n = 0 core, n = 1 loader):
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- reqN  in  1  access request, held until granted
- weN  in  1  1 = write, 0 = read
- addrN  in  ADDR_W  byte address
- wdataN  in  DATA_W  write data
- gntN  out  1  request accepted this cycle
- rvalidN  out  1  rdataN valid this cycle
- rdataN  out  DATA_W  read data, driven from mem_rdata
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after the sampling edge

## Operation
- States: IDLE, RD_WAIT.
- IDLE:
  - Pick the winner among asserted reqN.
  - If both requesters are asserted, grant the one not granted last (round-robin pointer `last`).
  - Drive gnt_winner=1, mem_en=1, and mem_we/addr/wdata from the winner, all combinationally.
  - Update `last` to the winner.
- Write grant: complete in that cycle and stay in IDLE, so back-to-back writes are possible every cycle.
- Read grant:
  - Load cnt = RD_LAT-1, record owner, go to RD_WAIT.
- RD_WAIT:
  - All gnt=0, mem_en=0.
  - While cnt!=0, decrement.
  - When cnt==0, assert rvalid_owner=1 and return to IDLE.
- rdata0 and rdata1 both always equal mem_rdata; only rvalidN qualifies it.
- Handshake:
  - Requester holds reqN, weN, addrN and wdataN stable until gntN.
  - Dropping reqN before gntN abandons the request with no side effects.
  - reqN may stay high after gnt to issue the next access.
- Non-winning requester sees gnt=0 and retries automatically by holding req.
- Starvation bound: a continuously asserted request is granted within 1 + (RD_LAT+1) cycles.
- mem_en=0 when nothing is granted. mem_addr and mem_wdata then drive 0.

## Timing
- Reset values:
  - state=IDLE, cnt=0, owner=0, last=1 (core wins the first tie).
  - gnt0/1=0, rvalid0/1=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- A request asserted in cycle T while IDLE is granted in T (zero-cycle grant when uncontended).
- Read granted in T: rvalid in cycle T+RD_LAT. Next grant no earlier than T+RD_LAT+1.
- Write granted in T: memory writes at the edge ending T. Next grant possible in T+1.
- A read followed by a write from the same master reaches memory at T+RD_LAT+1.
- Simultaneous req0 and req1 with last=1: core granted; the loader is granted at the next IDLE cycle if still requesting.
- Reset asserted mid-RD_WAIT: immediate return to IDLE, no rvalid, the pending read is dropped. The requester reissues.
- RD_LAT=1: RD_WAIT lasts exactly one cycle, with rvalid in that cycle.

## Structure
- Shared package mem_arb_pkg:
  - typedef enum logic {IDLE, RD_WAIT} arb_state_t.
  - typedef logic req_id_t with constants REQ_CORE=0, REQ_LOAD=1.
  - localparam RD_LAT_MAX=4.
- One sub-module is natural: rr_arb2. It is a combinational two-way round-robin pick from req0, req1 and last, producing the winner and a valid flag.
- The FSM, counter, owner register and muxing stay in mem_arbiter.

## Test plan
- Core read only, RD_LAT=2, addr0=0x100, mem returns 0xDEADBEEF -> gnt0 in T, rvalid0 with rdata0=0xDEADBEEF in T+2, rvalid1 never asserted.
- Both request reads from reset -> core granted first, loader granted at T+RD_LAT+1, each rvalid only to its own port.
- Loader issues 4 back-to-back writes to 0x0..0xC with core idle -> gnt1 high for 4 consecutive cycles, mem_we=1 with matching addr/wdata each cycle.
- Both hold req continuously for 20 cycles, RD_LAT=1, reads -> grants alternate 0,1,0,1 and no gap exceeds 3 cycles.
- Reset pulsed in cycle T+1 of a read with RD_LAT=3 -> all outputs 0, no rvalid, state IDLE; a subsequent req0 is granted in the first cycle after reset deasserts.
- req1 dropped before grant while the core holds a read -> no loader access reaches memory, and the core read completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// Imported by the arbiter top and its round-robin picker.
package mem_arb_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } arb_state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ_CORE = 1'b0;
    localparam req_id_t REQ_LOAD = 1'b1;

    localparam int RD_LAT_MAX = 4;
    localparam int CNT_W      = $clog2(RD_LAT_MAX);

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a tie the requester that was not granted last wins.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic    req0_i,
    input  logic    req1_i,
    input  req_id_t last_i,
    output req_id_t winner_o,
    output logic    valid_o
);

    always_comb begin
        valid_o  = req0_i | req1_i;
        winner_o = REQ_CORE;
        if (req0_i && req1_i) begin
            winner_o = (last_i == REQ_CORE) ? REQ_LOAD : REQ_CORE;
        end else if (req1_i) begin
            winner_o = REQ_LOAD;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency memory between the core (port 0) and the loader (port 1).
// Writes complete in the grant cycle; reads hold the memory until rvalid.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output arb_state_t        dbg_state_o
);

    // Handshake: a requester holds reqN/weN/addrN/wdataN stable until gntN;
    // gntN marks the transfer, and for reads rvalidN later qualifies rdataN.

    arb_state_t           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    req_id_t              owner_q, owner_d;
    req_id_t              last_q, last_d;
    req_id_t              winner;
    logic                 pick_valid;

    rr_arb2 u_rr_arb2 (
        .req0_i   (req0),
        .req1_i   (req1),
        .last_i   (last_q),
        .winner_o (winner),
        .valid_o  (pick_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= REQ_CORE;
            last_q  <= REQ_LOAD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        last_d    = last_q;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        rvalid0   = 1'b0;
        rvalid1   = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        case (state_q)
            IDLE: begin
                // Reset is folded in so nothing is granted while it is held.
                if (pick_valid && !reset) begin
                    mem_en = 1'b1;
                    last_d = winner;
                    if (winner == REQ_LOAD) begin
                        gnt1      = 1'b1;
                        mem_we    = we1;
                        mem_addr  = addr1;
                        mem_wdata = wdata1;
                    end else begin
                        gnt0      = 1'b1;
                        mem_we    = we0;
                        mem_addr  = addr0;
                        mem_wdata = wdata0;
                    end
                    if (!mem_we) begin
                        state_d = RD_WAIT;
                        cnt_d   = CNT_W'(RD_LAT - 1);
                        owner_d = winner;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = IDLE;
                    if (owner_q == REQ_LOAD) begin
                        rvalid1 = 1'b1;
                    end else begin
                        rvalid0 = 1'b1;
                    end
                end
            end
        endcase
    end

    assign rdata0      = mem_rdata;
    assign rdata1      = mem_rdata;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a cycle-level reference model predicts every
// grant and read return; a monitor pops those predictions as the DUT responds.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int RD_LAT = 2;

    logic          clk    = 1'b0;
    logic          reset  = 1'b1;
    logic          req0   = 1'b0;
    logic          we0    = 1'b0;
    logic [AW-1:0] addr0  = '0;
    logic [DW-1:0] wdata0 = '0;
    logic          req1   = 1'b0;
    logic          we1    = 1'b0;
    logic [AW-1:0] addr1  = '0;
    logic [DW-1:0] wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    arb_state_t    dbg_state;

    typedef struct {
        int            cyc;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } rec_t;

    rec_t          gnt_q[2][$];
    rec_t          rv_q[2][$];
    logic [DW-1:0] tb_mem[logic [AW-1:0]];
    logic [DW-1:0] model_mem[logic [AW-1:0]];
    logic [DW-1:0] rd_pipe[RD_LAT];
    int            cyc       = 0;
    int            checks    = 0;
    int            errors    = 0;
    int            next_free = 0;
    int            last_port = 1;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .dbg_state_o(dbg_state)
    );

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory macro: writes at the edge ending the grant cycle, reads appear RD_LAT cycles later.
    always @(posedge clk) begin
        if (mem_en && mem_we) tb_mem[mem_addr] = mem_wdata;
        rd_pipe[0] <= (mem_en && !mem_we) ?
                      (tb_mem.exists(mem_addr) ? tb_mem[mem_addr] : init_val(mem_addr)) : '0;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RD_LAT-1];

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        return model_mem.exists(a) ? model_mem[a] : init_val(a);
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // ---------------- reference model ----------------
    // Memory is free again RD_LAT+1 cycles after a read grant; ties go to the port not served last.
    always @(negedge clk) begin : ref_model
        int   w;
        rec_t g;
        rec_t r;
        if (reset) begin
            next_free = 0;
            last_port = 1;
            rv_q[0].delete();
            rv_q[1].delete();
        end else if (cyc >= next_free && (req0 || req1)) begin
            w = (req0 && req1) ? 1 - last_port : (req0 ? 0 : 1);
            last_port = w;
            g.cyc  = cyc;
            g.we   = (w == 0) ? we0 : we1;
            g.addr = (w == 0) ? addr0 : addr1;
            g.data = (w == 0) ? wdata0 : wdata1;
            gnt_q[w].push_back(g);
            if (g.we) begin
                model_mem[g.addr] = g.data;
            end else begin
                next_free = cyc + RD_LAT + 1;
                r.cyc  = cyc + RD_LAT;
                r.we   = 1'b0;
                r.addr = g.addr;
                r.data = model_read(g.addr);
                rv_q[w].push_back(r);
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    function automatic void mon_port(input int p, input logic g, input logic rv, input logic [DW-1:0] rd);
        rec_t e;
        while (gnt_q[p].size() > 0 && gnt_q[p][0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL gnt%0d_missing: no grant seen, expected one at cycle %0d", p, gnt_q[p][0].cyc);
            void'(gnt_q[p].pop_front());
        end
        while (rv_q[p].size() > 0 && rv_q[p][0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL rvalid%0d_missing: no rvalid seen, expected one at cycle %0d", p, rv_q[p][0].cyc);
            void'(rv_q[p].pop_front());
        end
        if (g) begin
            if (gnt_q[p].size() == 0) begin
                checks++; errors++;
                $display("FAIL gnt%0d_unexpected: got grant at cycle %0d, expected none", p, cyc);
            end else begin
                e = gnt_q[p].pop_front();
                chk($sformatf("gnt%0d_cycle", p), 64'(cyc), 64'(e.cyc));
                chk($sformatf("gnt%0d_en_we", p), {62'b0, mem_en, mem_we}, {62'b0, 1'b1, e.we});
                chk($sformatf("gnt%0d_addr", p), 64'(mem_addr), 64'(e.addr));
                if (e.we) chk($sformatf("gnt%0d_wdata", p), 64'(mem_wdata), 64'(e.data));
            end
        end
        if (rv) begin
            if (rv_q[p].size() == 0 || rv_q[p][0].cyc != cyc) begin
                checks++; errors++;
                $display("FAIL rvalid%0d_unexpected: got rvalid at cycle %0d, expected none", p, cyc);
            end else begin
                e = rv_q[p].pop_front();
                chk($sformatf("rdata%0d", p), 64'(rd), 64'(e.data));
            end
        end
    endfunction

    initial begin : monitor
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                chk("rst_ctl", {58'b0, gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we}, 64'b0);
                chk("rst_bus", {mem_addr, mem_wdata}, 64'b0);
                chk("rst_state", 64'(dbg_state), 64'(IDLE));
            end else begin
                chk("gnt_excl", {63'b0, gnt0 & gnt1}, 64'b0);
                mon_port(0, gnt0, rvalid0, rdata0);
                mon_port(1, gnt1, rvalid1, rdata1);
                if (!gnt0 && !gnt1) begin
                    chk("idle_ctl", {62'b0, mem_en, mem_we}, 64'b0);
                    chk("idle_bus", {mem_addr, mem_wdata}, 64'b0);
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic drive(input int p, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    // Called just after a rising edge; returns just after the edge ending the grant cycle.
    task automatic access(input int p, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input int give_up, output logic granted);
        int waited;
        waited  = 0;
        granted = 1'b0;
        drive(p, 1'b1, w, a, d);
        forever begin
            @(negedge clk);
            #2;
            if ((p == 0) ? gnt0 : gnt1) begin
                granted = 1'b1;
                break;
            end
            waited++;
            if (give_up > 0 && waited >= give_up) break;
            if (waited > 50) begin
                checks++; errors++;
                $display("FAIL port%0d_timeout: no grant after %0d cycles, expected grant", p, waited);
                break;
            end
        end
        @(posedge clk);
        #1;
        drive(p, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin : stimulus
        logic g, g0, g1;
        tb_mem[32'h100]    = 32'hDEAD_BEEF;
        model_mem[32'h100] = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Uncontended core read.
        access(0, 1'b0, 32'h100, '0, 0, g);
        idle(4);

        // Simultaneous reads from both ports.
        fork
            access(0, 1'b0, 32'h20, '0, 0, g0);
            access(1, 1'b0, 32'h24, '0, 0, g1);
        join
        idle(4);

        // Back-to-back loader writes.
        for (int i = 0; i < 4; i++) access(1, 1'b1, AW'(i * 4), $urandom, 0, g);
        idle(2);

        // Continuous contention with reads.
        fork
            begin
                for (int i = 0; i < 10; i++) access(0, 1'b0, AW'($urandom_range(0, 15) * 4), '0, 0, g0);
            end
            begin
                for (int i = 0; i < 10; i++) access(1, 1'b0, AW'($urandom_range(0, 15) * 4), '0, 0, g1);
            end
        join
        idle(4);

        // Reset in the cycle after a read grant drops the read.
        access(0, 1'b0, 32'h100, '0, 0, g);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        access(0, 1'b0, 32'h104, '0, 0, g);
        idle(4);

        // Loader abandons a write while the core read is in flight.
        access(0, 1'b0, 32'h108, '0, 0, g);
        access(1, 1'b1, 32'h0, 32'hBAD0_BAD0, 1, g1);
        chk("abandon_gnt", {63'b0, g1}, 64'b0);
        idle(4);
        access(1, 1'b0, 32'h0, '0, 0, g);
        idle(4);

        // Random mixed traffic with occasional abandoned requests.
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    idle($urandom_range(0, 2));
                    access(0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15) * 4), $urandom,
                           ($urandom_range(0, 7) == 0) ? 1 : 0, g0);
                end
            end
            begin
                for (int i = 0; i < 30; i++) begin
                    idle($urandom_range(0, 2));
                    access(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15) * 4), $urandom,
                           ($urandom_range(0, 7) == 0) ? 1 : 0, g1);
                end
            end
        join
        idle(10);

        for (int p = 0; p < 2; p++) begin
            chk($sformatf("gnt%0d_left", p), 64'(gnt_q[p].size()), 64'd0);
            chk($sformatf("rvalid%0d_left", p), 64'(rv_q[p].size()), 64'd0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        checks++; errors++;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
